// File: rtl/accel_pkg.sv
// accel_pkg -- shared definitions for the accelerator task path.
//   ADDR_W      : regfile address width (depth 2**ADDR_W)
//   CNT_W       : entry counter width, one bit wider so a full regfile is countable
//   IR_W / ST_W : InexRecur and state data widths
//   loader_state_e : task_loader FSM state encoding
package accel_pkg;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IR_W   = 32;
  localparam int ST_W   = 18;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage : accel_pkg

// File: rtl/task_loader.sv
// task_loader -- streams task entries into the InexRecur and state regfiles,
// then hands control to the accelerator and waits for it to finish.
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o  : entry beat handshake (ready only while loading)
//   cmd_inexrecur_i            : InexRecur word of the entry
//   cmd_state_i                : state word of the entry
//   cmd_last_i                 : final entry of the task
//   ran_we/_w_addr/_w_data_*   : regfile write ports, one cycle after acceptance
//   is_start_o                 : registered start level to the accelerator
//   acc_done_i                 : accelerator completion pulse (honoured in RUN only)
//   done_o                     : one-cycle task-completion pulse
//   count_o                    : entries loaded in the current task
//   overflow_o                 : sticky, regfile filled without a last beat
module task_loader #(
  parameter int ADDR_W = accel_pkg::ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [accel_pkg::IR_W-1:0] cmd_inexrecur_i,
  input  logic [accel_pkg::ST_W-1:0] cmd_state_i,
  input  logic                       cmd_last_i,
  output logic                       ran_we_InexRecur_o,
  output logic [ADDR_W-1:0]          ran_w_addr_InexRecur_o,
  output logic [accel_pkg::IR_W-1:0] ran_w_data_InexRecur_o,
  output logic                       ran_we_state_o,
  output logic [ADDR_W-1:0]          ran_w_addr_state_o,
  output logic [accel_pkg::ST_W-1:0] ran_w_data_state_o,
  output logic                       is_start_o,
  input  logic                       acc_done_i,
  output logic                       done_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       overflow_o
);

  import accel_pkg::*;

  // Index of the final regfile entry; accepting a beat here ends the load.
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(2 ** ADDR_W - 1);

  loader_state_e     state_reg, state_next;
  logic              accept;
  logic              at_depth;

  // Write-stage register: one beat held for exactly one cycle.
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [IR_W-1:0]   ir_data_reg;
  logic [ST_W-1:0]   st_data_reg;

  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;
  logic              is_start_reg;
  logic              done_reg;

  assign cmd_ready_o = (state_reg == ST_LOAD);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign at_depth    = (count_reg == LAST_ADDR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: begin
        if (accept && (cmd_last_i || at_depth)) begin
          state_next = ST_FLUSH;
        end
      end
      // The last accepted beat is written here, before start is raised.
      ST_FLUSH: state_next = ST_RUN;
      ST_RUN: begin
        if (acc_done_i) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_LOAD;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      ir_data_reg  <= '0;
      st_data_reg  <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      is_start_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= accept;
      if (accept) begin
        addr_reg    <= count_reg[ADDR_W-1:0];
        ir_data_reg <= cmd_inexrecur_i;
        st_data_reg <= cmd_state_i;
        count_reg   <= count_reg + CNT_W'(1);
        if (at_depth && !cmd_last_i) begin
          overflow_reg <= 1'b1;
        end
      end
      // Clear on the edge entering DONE so the done cycle already shows zero.
      if ((state_reg == ST_RUN) && acc_done_i) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end
      // Registered from the next state: start is high exactly during RUN and
      // can never coincide with a write, which only happens in LOAD/FLUSH.
      is_start_reg <= (state_next == ST_RUN);
      done_reg     <= (state_next == ST_DONE);
    end
  end

  assign ran_we_InexRecur_o     = we_reg;
  assign ran_w_addr_InexRecur_o = addr_reg;
  assign ran_w_data_InexRecur_o = ir_data_reg;
  assign ran_we_state_o         = we_reg;
  assign ran_w_addr_state_o     = addr_reg;
  assign ran_w_data_state_o     = st_data_reg;
  assign is_start_o             = is_start_reg;
  assign done_o                 = done_reg;
  assign count_o                = count_reg;
  assign overflow_o             = overflow_reg;

endmodule : task_loader

// File: tb/tb_task_loader.sv
// tb_task_loader -- randomized bench for task_loader with a write scoreboard.
// The driver predicts each regfile write as it issues a beat; a monitor
// matches every observed write against those predictions.
module tb_task_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_ir = '0;
  logic [17:0] cmd_st = '0;
  logic        cmd_last = 1'b0;
  logic        we_ir, we_st;
  logic [11:0] addr_ir, addr_st;
  logic [31:0] data_ir;
  logic [17:0] data_st;
  logic        is_start;
  logic        acc_done = 1'b0;
  logic        done;
  logic [12:0] count;
  logic        overflow;

  task_loader dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cmd_valid_i            (cmd_valid),
    .cmd_ready_o            (cmd_ready),
    .cmd_inexrecur_i        (cmd_ir),
    .cmd_state_i            (cmd_st),
    .cmd_last_i             (cmd_last),
    .ran_we_InexRecur_o     (we_ir),
    .ran_w_addr_InexRecur_o (addr_ir),
    .ran_w_data_InexRecur_o (data_ir),
    .ran_we_state_o         (we_st),
    .ran_w_addr_state_o     (addr_st),
    .ran_w_data_state_o     (data_st),
    .is_start_o             (is_start),
    .acc_done_i             (acc_done),
    .done_o                 (done),
    .count_o                (count),
    .overflow_o             (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] ir;
    logic [17:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] dir_ir [3];
  logic [17:0] dir_st [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write must match the oldest prediction, in its predicted cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      failures++;
      checks++;
      $display("FAIL missed_write: no write seen, expected addr 0x%0h at cycle %0d", exp_q[0].addr, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (we_ir || we_st) begin
      exp_t e;
      chk("strobes_equal", {63'd0, we_ir}, {63'd0, we_st});
      chk("start_vs_write", {63'd0, is_start}, 64'd0);
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", addr_ir, data_ir);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        chk("addr_ir", 64'(addr_ir), 64'(e.addr));
        chk("addr_st", 64'(addr_st), 64'(e.addr));
        chk("data_ir", 64'(data_ir), 64'(e.ir));
        chk("data_st", 64'(data_st), 64'(e.st));
        $display("write addr=0x%03h ir=0x%08h st=0x%05h cycle=%0d", addr_ir, data_ir, data_st, cyc);
      end
    end
  end

  // Issue one task's beats. A task ends on the last beat or when the
  // regfile (4096 entries) is full; filling it without last is an overflow.
  task automatic load_task(input int n, input bit use_last, input int gap_lo, input int gap_hi,
                           input bit directed, output int loaded, output bit exp_ovf);
    bit ended;
    int gap;
    exp_t e;
    loaded  = 0;
    exp_ovf = 0;
    ended   = 0;
    for (int i = 0; i < n && !ended; i++) begin
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gap; g++) begin
        cmd_valid = 0;
        acc_done  = ($urandom_range(3, 0) == 0);
        chk("idle_ready", {63'd0, cmd_ready}, 64'd1);
        chk("idle_count", 64'(count), 64'(loaded));
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_start", {63'd0, is_start}, 64'd0);
        step();
      end
      acc_done  = 0;
      cmd_valid = 1;
      cmd_ir    = directed ? dir_ir[i] : $urandom;
      cmd_st    = directed ? dir_st[i] : 18'($urandom);
      cmd_last  = use_last && (i == n - 1);
      chk("beat_ready", {63'd0, cmd_ready}, 64'd1);
      chk("beat_count", 64'(count), 64'(loaded));
      e.cyc  = cyc + 1;
      e.addr = 12'(loaded);
      e.ir   = cmd_ir;
      e.st   = cmd_st;
      exp_q.push_back(e);
      ended = cmd_last || (loaded == 4095);
      if (loaded == 4095 && !cmd_last) exp_ovf = 1;
      loaded++;
      step();
    end
  endtask

  // FLUSH, RUN, then completion by acc_done or by reset.
  task automatic finish_task(input int loaded, input bit exp_ovf, input bit do_reset);
    int run_len;
    // Keep offering a beat; none may be taken until the next task.
    cmd_valid = 1;
    cmd_ir    = $urandom;
    cmd_st    = 18'($urandom);
    cmd_last  = 0;
    chk("flush_ready", {63'd0, cmd_ready}, 64'd0);
    chk("flush_start", {63'd0, is_start}, 64'd0);
    chk("flush_count", 64'(count), 64'(loaded));
    chk("flush_ovf", {63'd0, overflow}, {63'd0, exp_ovf});
    step();
    run_len = $urandom_range(4, 1);
    for (int r = 0; r < run_len; r++) begin
      chk("run_start", {63'd0, is_start}, 64'd1);
      chk("run_ready", {63'd0, cmd_ready}, 64'd0);
      chk("run_count", 64'(count), 64'(loaded));
      chk("run_done", {63'd0, done}, 64'd0);
      step();
    end
    if (do_reset) begin
      cmd_valid = 0;
      rst_n     = 0;
      step();
      rst_n = 1;
      chk("rst_run_start", {63'd0, is_start}, 64'd0);
      chk("rst_run_count", 64'(count), 64'd0);
      chk("rst_run_ready", {63'd0, cmd_ready}, 64'd1);
      chk("rst_run_ovf", {63'd0, overflow}, 64'd0);
      $display("task loaded=%0d ended by reset in RUN", loaded);
    end else begin
      acc_done = 1;
      step();
      acc_done  = 0;
      cmd_valid = 0;
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("done_start", {63'd0, is_start}, 64'd0);
      chk("done_count", 64'(count), 64'd0);
      chk("done_ovf", {63'd0, overflow}, 64'd0);
      chk("done_ready", {63'd0, cmd_ready}, 64'd0);
      step();
      chk("after_done_ready", {63'd0, cmd_ready}, 64'd1);
      chk("after_done_pulse", {63'd0, done}, 64'd0);
      $display("task loaded=%0d overflow=%0d completed", loaded, exp_ovf);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int loaded;
    bit ovf;
    dir_ir[0] = 32'hA000_0001; dir_st[0] = 18'h00011;
    dir_ir[1] = 32'hA000_0002; dir_st[1] = 18'h00022;
    dir_ir[2] = 32'hA000_0003; dir_st[2] = 18'h00033;

    // Reset state, held across several edges with inputs idle.
    rst_n = 0;
    repeat (3) step();
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_we", {62'd0, we_ir, we_st}, 64'd0);
    chk("rst_addr", {40'd0, addr_ir, addr_st}, 64'd0);
    chk("rst_data", {14'd0, data_ir, data_st}, 64'd0);
    chk("rst_start", {63'd0, is_start}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    rst_n = 1;
    step();
    chk("release_ready", {63'd0, cmd_ready}, 64'd1);

    // Three directed back-to-back beats, last on the third.
    load_task(3, 1, 0, 0, 1, loaded, ovf);
    finish_task(loaded, ovf, 0);

    // Gapped valid: one on, two off; acc_done pulses while loading are ignored.
    load_task(4, 1, 2, 2, 0, loaded, ovf);
    finish_task(loaded, ovf, 0);

    // Random task lengths and gaps.
    for (int t = 0; t < 6; t++) begin
      load_task(int'($urandom_range(24, 1)), 1, 0, 3, 0, loaded, ovf);
      finish_task(loaded, ovf, 0);
    end

    // Fill the whole regfile without last: overflow, extra beats refused.
    load_task(4100, 0, 0, 0, 0, loaded, ovf);
    finish_task(loaded, ovf, 0);

    // Reset while running, then confirm a fresh task loads from address 0.
    load_task(5, 1, 0, 1, 0, loaded, ovf);
    finish_task(loaded, ovf, 1);
    load_task(3, 1, 0, 2, 0, loaded, ovf);
    finish_task(loaded, ovf, 0);

    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_task_loader

// File: doc/task_loader.md
TASK_LOADER -- requirements
Module: task_loader

Interface
REQ-001 Parameter ADDR_W, default 12: regfile address width, giving a depth of 4096 entries.
REQ-002 Parameter CNT_W, default 13 (ADDR_W+1): width of the entry counter.
REQ-003 clk  input  1  the single clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 cmd_valid_i  input  1  the upstream entry beat is valid.
REQ-006 cmd_ready_o  output  1  the loader can accept a beat.
REQ-007 cmd_inexrecur_i  input  32  InexRecur word for this entry.
REQ-008 cmd_state_i  input  18  state word for this entry.
REQ-009 cmd_last_i  input  1  this beat is the final entry of the task.
REQ-010 ran_we_InexRecur_o  output  1  write strobe to the regfile_InexRecur random write port.
REQ-011 ran_w_addr_InexRecur_o  output  12  InexRecur write address.
REQ-012 ran_w_data_InexRecur_o  output  32  InexRecur write data.
REQ-013 ran_we_state_o  output  1  write strobe to the regfile_state external random write port.
REQ-014 ran_w_addr_state_o  output  12  state write address.
REQ-015 ran_w_data_state_o  output  18  state write data.
REQ-016 is_start_o  output  1  start level to the accelerator, which also selects its internal state write path.
REQ-017 acc_done_i  input  1  completion pulse from the accelerator FSM.
REQ-018 done_o  output  1  one-cycle pulse marking task completion.
REQ-019 count_o  output  13  number of entries loaded in the current task.
REQ-020 overflow_o  output  1  sticky flag: depth was reached without cmd_last_i.

Function
REQ-021 The FSM SHALL have four states: LOAD, FLUSH, RUN, DONE.
REQ-022 In LOAD, cmd_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-023 A beat SHALL be accepted on a rising edge where cmd_valid_i && cmd_ready_o.
REQ-024 An accepted beat SHALL be written in the following cycle: both write strobes = 1, both addresses = count_o (pre-increment), data = the registered beat fields.
REQ-025 Write latency SHALL be exactly 1 cycle from acceptance; strobes SHALL be 0 in any cycle not following an acceptance.
REQ-026 count_o SHALL increment by 1 on each acceptance.
REQ-027 Back-to-back beats SHALL be accepted every cycle with no bubble.
REQ-028 An accepted beat with cmd_last_i = 1 SHALL move the FSM LOAD -> FLUSH.
REQ-029 An accepted beat at address 2^ADDR_W-1 SHALL also move the FSM LOAD -> FLUSH; if cmd_last_i = 0 on that beat, overflow_o SHALL be set.
REQ-030 FLUSH SHALL last one cycle, during which the final write occurs with is_start_o = 0; the FSM SHALL then go to RUN.
REQ-031 In RUN, is_start_o SHALL be 1 continuously and no writes SHALL occur.
REQ-032 acc_done_i = 1 in RUN SHALL move the FSM to DONE; acc_done_i SHALL be ignored in all other states.
REQ-033 In DONE: done_o = 1 and is_start_o = 0 for one cycle; count_o and overflow_o SHALL clear; the FSM SHALL return to LOAD.
REQ-034 is_start_o SHALL be registered and glitch-free, and SHALL never be 1 in the same cycle as a write strobe.
REQ-035 When cmd_valid_i = 0 in LOAD, the FSM SHALL hold its state and count_o SHALL not change.

Reset
REQ-036 While rst_n = 0 at a clock edge, the FSM SHALL go to LOAD, and count_o, overflow_o, done_o, is_start_o, all strobes, addresses and data SHALL become 0.
REQ-037 A reset asserted mid-load or mid-RUN SHALL abandon the task; is_start_o = 0 from the next edge, and the regfile contents are not restored.
REQ-038 cmd_ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-039 The state encoding, ADDR_W, and the InexRecur (32) and state (18) data widths SHALL live in the shared package accel_pkg.
REQ-040 The module SHALL be a single module with no sub-modules; the write-stage register is inline.

Verification
REQ-041 Reset, then 3 beats (0xA0000001/0x00011, 0xA0000002/0x00022, 0xA0000003/0x00033, last on beat 3) -> writes to addresses 0, 1, 2 in consecutive cycles; FLUSH; then is_start_o = 1; count_o = 3.
REQ-042 Drive acc_done_i = 1 for one cycle in RUN -> next cycle is_start_o = 0 and done_o = 1, count_o = 0; following cycle cmd_ready_o = 1.
REQ-043 4096 beats with cmd_last_i = 0 throughout -> final write at address 0xFFF, overflow_o = 1, RUN entered, 4097th beat not accepted.
REQ-044 Gapped valid (1 cycle on, 2 cycles off, for 4 beats) -> addresses 0..3 with no duplicate or skipped writes.
REQ-045 Assert rst_n = 0 during RUN -> next edge is_start_o = 0, count_o = 0, FSM in LOAD.
REQ-046 Pulse acc_done_i in LOAD -> no state change and done_o stays 0.
